bcd_to_binary_seq: RTL and testbench
====================================

// Module: bcd_to_binary_seq
// PURPOSE
//  Multi-cycle converter from packed BCD digits back to an unsigned binary value,
//  the inverse of the combinational binary-to-decimal splitter in the display path.
//  Used where keypad or display-side decimal entry must be fed back to binary datapaths.
//  Iterates multiply-by-10 accumulate, one digit per clock, MSD first, with ready/valid on both sides.
// PARAMETERS
//  DIGITS  2  number of BCD digits in bcd_in (>=1)
//  BIN_W   7  width of bin_out; values >= 2**BIN_W flag ovf and saturate
// PORTS
//  clk        in   1           single clock, rising edge
//  rst_n      in   1           asynchronous active-low reset
//  in_valid   in   1           bcd_in is valid this cycle
//  in_ready   out  1           converter can accept an input (high only in IDLE)
//  bcd_in     in   4*DIGITS    packed BCD, digit 0 = bcd_in[3:0] = least significant
//  out_valid  out  1           bin_out/err/ovf valid, held until accepted
//  out_ready  in   1           downstream accepts result
//  bin_out    out  BIN_W       converted value
//  err        out  1           at least one input nibble > 9
//  ovf        out  1           true value >= 2**BIN_W (bin_out saturated)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, out_valid=0, bin_out=0, err=0, ovf=0, in_ready=1
//   on the first clk after release; internal acc/count cleared. Reset mid-CONV or in DONE
//   aborts immediately; the pending result is discarded.
//  Internal accumulator width ACC_W = clog2(10**DIGITS); no internal wrap.
//  FSM:
//   IDLE: in_ready=1. On in_valid&&in_ready edge: latch bcd_in, acc=0, idx=DIGITS-1,
//         err_r = OR over nibbles of (nibble>9); -> CONV.
//   CONV: in_ready=0. Each edge: acc = acc*10 + digit[idx]; idx--; after digit 0 -> DONE.
//         Nibbles >9 still accumulated (result discarded below); timing is data-independent.
//   DONE: out_valid=1, outputs stable. If err_r: bin_out=0, err=1, ovf=0.
//         Else if acc >= 2**BIN_W: bin_out=all ones, ovf=1. Else bin_out=acc[BIN_W-1:0].
//         On out_valid&&out_ready edge -> IDLE, out_valid=0 (bin_out/err/ovf hold last value).
//  Latency: input accepted at edge N -> out_valid high after edge N+DIGITS.
//  Throughput: one conversion per DIGITS+2 cycles with out_ready tied high.
//  Backpressure: out_ready low holds DONE indefinitely; in_ready stays 0; no inputs lost
//   or overwritten. in_valid while in_ready=0 is ignored (upstream must hold).
//  out_ready while out_valid=0 has no effect. Simultaneous out handshake and in_valid
//   in DONE: only the output handshake completes; input accepted next cycle in IDLE.
//  in_ready, out_valid, bin_out, err, ovf are registered or pure state decodes (no comb path
//   from inputs to outputs).
// TESTING
//  Reset: assert rst_n=0 mid-CONV -> out_valid=0, bin_out=0, in_ready=1 after release; no stale result.
//  Basic: bcd_in=8'h42, in_valid 1 cycle, out_ready=1 -> out_valid after 2 edges, bin_out=42, err=0, ovf=0.
//  Bounds: 8'h00 -> 0; 8'h99 -> 99; back-to-back inputs each accepted only when in_ready=1.
//  Invalid: bcd_in=8'h1A -> bin_out=0, err=1, ovf=0, same latency as valid input.
//  Backpressure: out_ready=0 for 10 cycles after 8'h57 -> out_valid, bin_out=57 stable throughout,
//   in_ready=0, new in_valid ignored; release out_ready -> return to IDLE next edge.
//  Overflow: DIGITS=3, BIN_W=8, bcd_in=12'h300 -> bin_out=255, ovf=1; 12'h255 -> 255, ovf=0.

Source files
------------

// File: rtl/bcd_to_binary_seq.sv
// Sequential packed-BCD to unsigned binary converter.
// Consumes one decimal digit per clock, most significant digit first, using a
// multiply-by-10 accumulate. Ready/valid handshakes on both sides. Every
// output is a flop, so there is no combinational path from inputs to outputs.
//
// Ports:
//   clk, rst_n             rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready    input handshake; in_ready is high only in IDLE
//   bcd_in                 packed BCD, digit 0 = bcd_in[3:0] (least significant)
//   out_valid / out_ready  output handshake; the result is held until accepted
//   bin_out                converted value (0 on err, all ones on ovf)
//   err                    at least one input nibble was greater than 9
//   ovf                    true value >= 2**BIN_W, so bin_out is saturated
module bcd_to_binary_seq #(
    parameter int unsigned DIGITS = 2,
    parameter int unsigned BIN_W  = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  err,
    output logic                  ovf
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    // 10**DIGITS is never a power of two, so ACC_W bits hold 10**DIGITS - 1
    localparam int unsigned ACC_W = $clog2(10 ** DIGITS);
    localparam int unsigned CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned CMP_W = ((ACC_W > BIN_W) ? ACC_W : BIN_W) + 1;
    localparam logic [CMP_W-1:0] SAT_LIMIT = CMP_W'(1) << BIN_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [BCD_W-1:0]   bcd_sh;
    logic [BCD_W-1:0]   bcd_sh_nxt;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               err_r;
    logic               err_r_nxt;

    logic               in_ready_nxt;
    logic               out_valid_nxt;
    logic [BIN_W-1:0]   bin_out_nxt;
    logic               err_nxt;
    logic               ovf_nxt;

    logic [3:0]         cur_digit;
    logic [ACC_W-1:0]   acc_step;
    logic [CMP_W-1:0]   acc_ext;
    logic               acc_over;

    // Flags any nibble above 9 in a packed BCD word
    function automatic logic has_bad_nibble(input logic [BCD_W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

    // Digits are shifted up so the current one is always the top nibble
    always_comb begin
        cur_digit = bcd_sh[BCD_W-1 -: 4];
        acc_step  = acc * ACC_W'(10) + ACC_W'(cur_digit);
        acc_ext   = CMP_W'(acc_step);
        acc_over  = (acc_ext >= SAT_LIMIT);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nxt = CONV;
                end
            end
            CONV: begin
                if (cnt == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath and next values of the registered outputs
    always_comb begin
        bcd_sh_nxt    = bcd_sh;
        acc_nxt       = acc;
        cnt_nxt       = cnt;
        err_r_nxt     = err_r;
        bin_out_nxt   = bin_out;
        err_nxt       = err;
        ovf_nxt       = ovf;
        in_ready_nxt  = (state_nxt == IDLE);
        out_valid_nxt = (state_nxt == DONE);

        case (state)
            IDLE: begin
                if (in_valid) begin
                    bcd_sh_nxt = bcd_in;
                    acc_nxt    = '0;
                    cnt_nxt    = CNT_W'(DIGITS - 1);
                    err_r_nxt  = has_bad_nibble(bcd_in);
                end
            end
            CONV: begin
                acc_nxt    = acc_step;
                bcd_sh_nxt = bcd_sh << 4;
                if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else begin
                    // Last digit: resolve the result as it enters DONE
                    if (err_r) begin
                        bin_out_nxt = '0;
                        err_nxt     = 1'b1;
                        ovf_nxt     = 1'b0;
                    end else if (acc_over) begin
                        bin_out_nxt = '1;
                        err_nxt     = 1'b0;
                        ovf_nxt     = 1'b1;
                    end else begin
                        bin_out_nxt = BIN_W'(acc_step);
                        err_nxt     = 1'b0;
                        ovf_nxt     = 1'b0;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_sh    <= '0;
            acc       <= '0;
            cnt       <= '0;
            err_r     <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            bin_out   <= '0;
            err       <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            bcd_sh    <= bcd_sh_nxt;
            acc       <= acc_nxt;
            cnt       <= cnt_nxt;
            err_r     <= err_r_nxt;
            in_ready  <= in_ready_nxt;
            out_valid <= out_valid_nxt;
            bin_out   <= bin_out_nxt;
            err       <= err_nxt;
            ovf       <= ovf_nxt;
        end
    end

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Testbench for bcd_to_binary_seq.
// Instance A uses the default 2-digit / 7-bit configuration and is tracked
// every cycle against a transaction-level model. Instance B (3 digits, 8 bits)
// covers saturation and is checked per conversion.
module tb_bcd_to_binary_seq;

    localparam int unsigned A_D = 2;
    localparam int unsigned A_W = 7;
    localparam int unsigned B_D = 3;
    localparam int unsigned B_W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic             a_in_valid = 1'b0;
    logic             a_in_ready;
    logic [4*A_D-1:0] a_bcd = '0;
    logic             a_out_valid;
    logic             a_out_ready = 1'b0;
    logic [A_W-1:0]   a_bin;
    logic             a_err;
    logic             a_ovf;

    logic             b_in_valid = 1'b0;
    logic             b_in_ready;
    logic [4*B_D-1:0] b_bcd = '0;
    logic             b_out_valid;
    logic             b_out_ready = 1'b0;
    logic [B_W-1:0]   b_bin;
    logic             b_err;
    logic             b_ovf;

    bcd_to_binary_seq #(.DIGITS(A_D), .BIN_W(A_W)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .bcd_in    (a_bcd),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .bin_out   (a_bin),
        .err       (a_err),
        .ovf       (a_ovf)
    );

    bcd_to_binary_seq #(.DIGITS(B_D), .BIN_W(B_W)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .bcd_in    (b_bcd),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .bin_out   (b_bin),
        .err       (b_err),
        .ovf       (b_ovf)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference conversion straight from the decimal definition
    function automatic void ref_conv(input logic [31:0] bcd, input int digits, input int bw,
                                     output int unsigned bin, output bit e, output bit o);
        longint unsigned v;
        logic [3:0] nib;
        v = 0;
        e = 1'b0;
        for (int i = digits - 1; i >= 0; i--) begin
            nib = bcd[4*i +: 4];
            if (nib > 4'd9) e = 1'b1;
            v = v * 10 + longint'(nib);
        end
        if (e) begin
            bin = 0;
            o   = 1'b0;
        end else if (v >= (64'd1 << bw)) begin
            bin = int'((64'd1 << bw) - 1);
            o   = 1'b1;
        end else begin
            bin = int'(v);
            o   = 1'b0;
        end
    endfunction

    function automatic logic [4*A_D-1:0] rbcd_a();
        if ($urandom_range(0, 7) == 0) return (4*A_D)'($urandom);
        return {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
    endfunction

    function automatic logic [4*B_D-1:0] rbcd_b();
        if ($urandom_range(0, 7) == 0) return (4*B_D)'($urandom);
        return {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
    endfunction

    // Transaction model of instance A: busy from accept until the result is taken,
    // result visible DIGITS edges after accept, last result held afterwards
    bit          m_busy = 1'b0;
    bit          m_done = 1'b0;
    int          m_rem  = 0;
    int unsigned m_bin  = 0;
    bit          m_err  = 1'b0;
    bit          m_ovf  = 1'b0;
    int unsigned p_bin  = 0;
    bit          p_err  = 1'b0;
    bit          p_ovf  = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_busy = 1'b0; m_done = 1'b0; m_rem = 0;
                m_bin = 0; m_err = 1'b0; m_ovf = 1'b0;
            end else if (!m_busy) begin
                if (a_in_valid) begin
                    ref_conv(32'(a_bcd), A_D, A_W, p_bin, p_err, p_ovf);
                    m_busy = 1'b1;
                    m_rem  = A_D;
                end
            end else if (!m_done) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_done = 1'b1;
                    m_bin = p_bin; m_err = p_err; m_ovf = p_ovf;
                end
            end else if (a_out_ready) begin
                m_busy = 1'b0;
                m_done = 1'b0;
            end
        end
    end

    // Cycle-by-cycle comparison of instance A against the model
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("a_in_ready",  64'(a_in_ready),  64'(!m_busy));
            chk("a_out_valid", 64'(a_out_valid), 64'(m_done));
            chk("a_bin_out",   64'(a_bin),       64'(m_bin));
            chk("a_err",       64'(a_err),       64'(m_err));
            chk("a_ovf",       64'(a_ovf),       64'(m_ovf));
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic conv_a(input logic [4*A_D-1:0] bcd, input int unsigned eb, input bit ee, input bit eo);
        int w = 0;
        int lat = 0;
        while (!a_in_ready && w < 20) begin step(); w++; end
        chk("a_accept_wait", 64'(a_in_ready), 64'd1);
        a_bcd = bcd; a_in_valid = 1'b1; a_out_ready = 1'b1;
        step();
        a_in_valid = 1'b0;
        while (!a_out_valid && lat < 20) begin step(); lat++; end
        chk($sformatf("a_latency_%h", bcd), 64'(lat), 64'(A_D));
        chk($sformatf("a_bin_%h", bcd), 64'(a_bin), 64'(eb));
        chk($sformatf("a_err_%h", bcd), 64'(a_err), 64'(ee));
        chk($sformatf("a_ovf_%h", bcd), 64'(a_ovf), 64'(eo));
        step();
        chk($sformatf("a_release_%h", bcd), 64'(a_out_valid), 64'd0);
    endtask

    task automatic conv_b(input logic [4*B_D-1:0] bcd, input int unsigned eb, input bit ee, input bit eo);
        int w = 0;
        int lat = 0;
        while (!b_in_ready && w < 20) begin step(); w++; end
        chk("b_accept_wait", 64'(b_in_ready), 64'd1);
        b_bcd = bcd; b_in_valid = 1'b1; b_out_ready = 1'b1;
        step();
        b_in_valid = 1'b0;
        while (!b_out_valid && lat < 20) begin step(); lat++; end
        chk($sformatf("b_latency_%h", bcd), 64'(lat), 64'(B_D));
        chk($sformatf("b_bin_%h", bcd), 64'(b_bin), 64'(eb));
        chk($sformatf("b_err_%h", bcd), 64'(b_err), 64'(ee));
        chk($sformatf("b_ovf_%h", bcd), 64'(b_ovf), 64'(eo));
        step();
        chk($sformatf("b_release_%h", bcd), 64'(b_out_valid), 64'd0);
    endtask

    initial begin
        int unsigned eb;
        bit ee;
        bit eo;
        int lat;
        int cnt;
        logic [4*B_D-1:0] rb;

        repeat (3) step();
        rst_n = 1'b1;
        step();
        chk("reset_a_in_ready",  64'(a_in_ready),  64'd1);
        chk("reset_a_out_valid", 64'(a_out_valid), 64'd0);
        chk("reset_a_bin_out",   64'(a_bin),       64'd0);
        chk("reset_b_in_ready",  64'(b_in_ready),  64'd1);

        // Model pins
        ref_conv(32'h300, 3, 8, eb, ee, eo);
        chk("model_300", 64'({eb, ee, eo}), 64'({32'd255, 1'b0, 1'b1}));
        ref_conv(32'h1A, 2, 7, eb, ee, eo);
        chk("model_1A", 64'({eb, ee, eo}), 64'({32'd0, 1'b1, 1'b0}));

        // Directed conversions on A
        conv_a(8'h42, 42, 1'b0, 1'b0);
        conv_a(8'h00, 0,  1'b0, 1'b0);
        conv_a(8'h99, 99, 1'b0, 1'b0);
        conv_a(8'h1A, 0,  1'b1, 1'b0);
        conv_a(8'hF3, 0,  1'b1, 1'b0);
        conv_a(8'h07, 7,  1'b0, 1'b0);

        // Backpressure: result held, new inputs ignored
        a_out_ready = 1'b0; a_bcd = 8'h57; a_in_valid = 1'b1;
        step();
        a_in_valid = 1'b0;
        lat = 0;
        while (!a_out_valid && lat < 20) begin step(); lat++; end
        chk("bp_latency", 64'(lat), 64'(A_D));
        for (int i = 0; i < 10; i++) begin
            a_in_valid = 1'b1; a_bcd = 8'h11;
            step();
            chk("bp_out_valid", 64'(a_out_valid), 64'd1);
            chk("bp_bin_out",   64'(a_bin),       64'd57);
            chk("bp_in_ready",  64'(a_in_ready),  64'd0);
        end
        a_in_valid = 1'b0; a_out_ready = 1'b1;
        step();
        chk("bp_done_valid", 64'(a_out_valid), 64'd0);
        chk("bp_done_ready", 64'(a_in_ready),  64'd1);
        chk("bp_hold_bin",   64'(a_bin),       64'd57);

        // Reset in the middle of a conversion
        a_bcd = 8'h99; a_in_valid = 1'b1;
        step();
        a_in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", 64'(a_out_valid), 64'd0);
        chk("rst_async_ready", 64'(a_in_ready),  64'd1);
        chk("rst_async_bin",   64'(a_bin),       64'd0);
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rst_no_stale_valid", 64'(a_out_valid), 64'd0);
            chk("rst_no_stale_bin",   64'(a_bin),       64'd0);
            chk("rst_no_stale_ready", 64'(a_in_ready),  64'd1);
        end

        // Throughput with continuous input and output_ready high
        a_bcd = 8'h12; a_in_valid = 1'b1; a_out_ready = 1'b1;
        cnt = 0;
        for (int i = 0; i < 4 * int'(A_D + 2); i++) begin
            step();
            if (a_out_valid) cnt++;
        end
        chk("throughput", 64'(cnt), 64'd4);
        a_in_valid = 1'b0;
        repeat (A_D + 3) step();

        // Randomized traffic on A, checked by the per-cycle compare
        for (int i = 0; i < 600; i++) begin
            a_in_valid  = 1'($urandom_range(0, 1));
            a_bcd       = rbcd_a();
            a_out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        a_in_valid = 1'b0; a_out_ready = 1'b1;
        repeat (A_D + 3) step();

        // Saturation and range on B
        conv_b(12'h042, 42,  1'b0, 1'b0);
        conv_b(12'h000, 0,   1'b0, 1'b0);
        conv_b(12'h300, 255, 1'b0, 1'b1);
        conv_b(12'h255, 255, 1'b0, 1'b0);
        conv_b(12'h256, 255, 1'b0, 1'b1);
        conv_b(12'h999, 255, 1'b0, 1'b1);
        conv_b(12'h127, 127, 1'b0, 1'b0);
        conv_b(12'hF00, 0,   1'b1, 1'b0);
        conv_b(12'h09B, 0,   1'b1, 1'b0);
        for (int i = 0; i < 30; i++) begin
            rb = rbcd_b();
            ref_conv(32'(rb), B_D, B_W, eb, ee, eo);
            conv_b(rb, eb, ee, eo);
        end

        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
